// File: rtl/spr_line_feeder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spr_line_feeder
//
// Sprite line sequencer. On each NEWLINE pulse it walks the sprite attribute
// table, picks the sprites whose 16-line band covers the target line and, for
// each one, issues a LACH strobe with colour/X/flip, then one CARY strobe per
// 8-pixel chunk with the matching graphics ROM row address. HEND closes the line.
//
// Ports
//   clk_12M  : sole clock, rising edge
//   nRES     : asynchronous active-low reset
//   NEWLINE  : one-cycle pulse, starts (or restarts) a scan for LINE
//   LINE     : target raster line, sampled with NEWLINE
//   ATTR_A   : attribute RAM address (current table index)
//   ATTR_D   : attribute entry, valid one cycle after ATTR_A
//   CA       : graphics ROM row address {CODE, row, chunk}
//   OC/HP/OHF: colour, start X, horizontal flip of the latched sprite
//   LACH     : new-sprite strobe
//   CARY     : per-chunk strobe
//   HEND     : end-of-line strobe
//   BUSY     : scan in progress (NEWLINE .. HEND)
// -----------------------------------------------------------------------------
module spr_line_feeder #(
  parameter int NSPR   = 128,
  parameter int MAXSPR = 32
) (
  input  logic                    clk_12M,
  input  logic                    nRES,
  input  logic                    NEWLINE,
  input  logic [7:0]              LINE,
  output logic [$clog2(NSPR)-1:0] ATTR_A,
  input  logic [39:0]             ATTR_D,
  output logic [16:0]             CA,
  output logic [7:0]              OC,
  output logic [8:0]              HP,
  output logic                    OHF,
  output logic                    LACH,
  output logic                    CARY,
  output logic                    HEND,
  output logic                    BUSY
);

  localparam int AW = $clog2(NSPR);
  localparam int NW = $clog2(MAXSPR + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NSPR - 1);
  localparam logic [NW-1:0] MAX_CNT  = NW'(MAXSPR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_LATCH,
    S_DRAW,
    S_DONE
  } state_t;

  // Attribute entry fields
  logic        w_active;
  logic        w_hflip;
  logic [1:0]  w_wm1;
  logic [7:0]  w_color;
  logic [8:0]  w_x;
  logic [7:0]  w_y;
  logic [10:0] w_code;

  assign w_active = ATTR_D[39];
  assign w_hflip  = ATTR_D[38];
  assign w_wm1    = ATTR_D[37:36];
  assign w_color  = ATTR_D[35:28];
  assign w_x      = ATTR_D[27:19];
  assign w_y      = ATTR_D[18:11];
  assign w_code   = ATTR_D[10:0];

  state_t      r_state;
  logic [7:0]  r_line;
  logic [AW-1:0] r_idx;
  logic [NW-1:0] r_cnt;
  logic        r_hflip;
  logic [1:0]  r_wm1;
  logic [10:0] r_code;
  logic [3:0]  r_row;
  logic [1:0]  r_k;
  logic [1:0]  r_ph;
  logic [16:0] r_ca;
  logic [7:0]  r_oc;
  logic [8:0]  r_hp;
  logic        r_ohf;
  logic        r_lach;
  logic        r_cary;
  logic        r_hend;
  logic        r_busy;

  // Line offset into the sprite band; 8-bit wrap makes sprites that start near
  // the bottom of the frame continue at the top.
  logic [7:0]  w_d;
  logic        w_visible;
  logic [1:0]  w_next_k;
  logic [1:0]  w_chunk;
  logic [16:0] w_ca_next;

  // NOTE: every signal written in always_comb gets a default first so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    w_d       = r_line - w_y;
    w_visible = w_active && (w_d[7:4] == 4'd0);
    // Slot index of the slot about to start: 0 when leaving LATCH, k+1 in DRAW.
    w_next_k  = (r_state == S_DRAW) ? r_k + 2'd1 : 2'd0;
    w_chunk   = r_hflip ? (r_wm1 - w_next_k) : w_next_k;
    w_ca_next = {r_code, r_row, w_chunk};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: every register, including the held sprite fields, is cleared by
  // the asynchronous reset so outputs drop to 0 immediately.
  always_ff @(posedge clk_12M or negedge nRES) begin
    if (!nRES) begin
      r_state <= S_IDLE;
      r_line  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_hflip <= 1'b0;
      r_wm1   <= '0;
      r_code  <= '0;
      r_row   <= '0;
      r_k     <= '0;
      r_ph    <= '0;
      r_ca    <= '0;
      r_oc    <= '0;
      r_hp    <= '0;
      r_ohf   <= 1'b0;
      r_lach  <= 1'b0;
      r_cary  <= 1'b0;
      r_hend  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      r_lach <= 1'b0;
      r_cary <= 1'b0;
      r_hend <= 1'b0;

      if (NEWLINE) begin
        // Start of a line, or abort of the running one: same restart either way.
        r_line  <= LINE;
        r_idx   <= '0;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
        r_state <= S_FETCH;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end

          // ATTR_A already holds the index; wait for the RAM read.
          S_FETCH: begin
            r_state <= S_EVAL;
          end

          S_EVAL: begin
            if (w_visible) begin
              r_hflip <= w_hflip;
              r_wm1   <= w_wm1;
              r_code  <= w_code;
              r_row   <= w_d[3:0];
              r_oc    <= w_color;
              r_hp    <= w_x;
              r_ohf   <= w_hflip;
              r_lach  <= 1'b1;
              r_cnt   <= r_cnt + 1'b1;
              r_state <= S_LATCH;
            end else if (r_idx == LAST_IDX) begin
              r_hend  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_FETCH;
            end
          end

          S_LATCH: begin
            r_k     <= 2'd0;
            r_ph    <= 2'd0;
            r_cary  <= 1'b1;
            r_ca    <= w_ca_next;
            r_state <= S_DRAW;
          end

          // Each slot lasts four cycles; CARY and the new CA land on phase 0.
          S_DRAW: begin
            r_ph <= r_ph + 2'd1;
            if (r_ph == 2'd3) begin
              if (r_k == r_wm1) begin
                if (r_cnt == MAX_CNT || r_idx == LAST_IDX) begin
                  r_hend  <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_FETCH;
                end
              end else begin
                r_k    <= w_next_k;
                r_cary <= 1'b1;
                r_ca   <= w_ca_next;
              end
            end
          end

          // HEND is high in this cycle; BUSY drops on the way out.
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ATTR_A = r_idx;
  assign CA     = r_ca;
  assign OC     = r_oc;
  assign HP     = r_hp;
  assign OHF    = r_ohf;
  assign LACH   = r_lach;
  assign CARY   = r_cary;
  assign HEND   = r_hend;
  assign BUSY   = r_busy;

endmodule

// File: doc/spr_line_feeder.md
# spr_line_feeder

Sprite line sequencer driving the sprite data processor's command inputs. On each new line it walks the sprite attribute table, selects sprites whose 16-line band covers the target line, and emits per-sprite LACH/OC/HP/OHF commands. It then emits per-chunk CARY strobes with matching graphics ROM addresses and closes the line with HEND. It sits between attribute RAM / graphics ROM addressing and the processor's OC, HP, OHF, LACH, CARY and HEND inputs.

## Interface
Parameters:
- NSPR, 128: attribute table entries; ATTR_A width = clog2(NSPR).
- MAXSPR, 32: maximum sprites emitted per line.

Ports:
- clk_12M  in  1  sole clock; all logic on rising edge.
- nRES  in  1  asynchronous, active-low reset.
- NEWLINE  in  1  one-cycle pulse that starts a scan for LINE.
- LINE  in  8  target raster line, sampled when NEWLINE=1.
- ATTR_A  out  clog2(NSPR)  attribute RAM address.
- ATTR_D  in  40  entry, valid 1 cycle after ATTR_A. Fields: [39] ACTIVE, [38] HFLIP, [37:36] WM1 (width in 8px chunks minus 1), [35:28] COLOR, [27:19] X, [18:11] Y, [10:0] CODE.
- CA  out  17  graphics ROM row address {CODE, row[3:0], chunk[1:0]}.
- OC  out  8  sprite colour/palette, held from LACH until the next LACH.
- HP  out  9  sprite start X, held from LACH until the next LACH.
- OHF  out  1  horizontal flip, held from LACH until the next LACH.
- LACH  out  1  one-cycle new-sprite strobe.
- CARY  out  1  one-cycle strobe per 8px chunk.
- HEND  out  1  one-cycle end-of-line strobe.
- BUSY  out  1  high from NEWLINE until HEND.

## Operation
- States: IDLE, FETCH, EVAL, LATCH, DRAW, DONE.
- IDLE: NEWLINE=1 latches LINE, clears index I and emitted count N, and goes to FETCH.
- FETCH: drive ATTR_A=I, then go to EVAL.
- EVAL: d = LINE − Y, modulo 256, 8-bit.
  - Visible if ACTIVE=1 and d<16; then latch the entry and row=d[3:0], and go to LATCH.
  - Otherwise I=I+1 and go to FETCH.
  - If I was NSPR−1, go to DONE instead.
- LATCH: LACH=1; OC=COLOR, HP=X, OHF=HFLIP register on this cycle; N=N+1; go to DRAW with slot k=0.
- DRAW: WM1+1 slots of 4 cycles each.
  - CARY=1 on the first cycle of each slot.
  - CA is constant for the whole slot.
  - Chunk index c=k when HFLIP=0, c=WM1−k when HFLIP=1.
  - After the last slot: go to DONE if N=MAXSPR or I=NSPR−1; otherwise I=I+1 and go to FETCH.
- DONE: HEND=1 for one cycle, then IDLE.
- NEWLINE outside IDLE aborts the scan: no HEND for the aborted line, restart from FETCH with I=0, N=0 and the new LINE. CARY/LACH are never emitted in the same cycle as the abort.
- Y wrap: Y=250, LINE=3 gives d=9, so the sprite is visible.
- X is passed through unchanged; X≥384 is still emitted. The processor discards off-screen pixels.

## Timing
- Reset: state IDLE; all outputs 0 (ATTR_A, CA, OC, HP, OHF, LACH, CARY, HEND, BUSY).
- Invisible entry costs 2 cycles; visible entry costs 3+4·(WM1+1) cycles.
- LACH occurs 2 cycles after its FETCH.
- First CARY occurs 1 cycle after LACH; subsequent CARYs are 4 cycles apart.
- HEND occurs 1 cycle after the final EVAL or the final DRAW cycle.
- BUSY rises the cycle after NEWLINE and falls with HEND (BUSY=0 in the cycle after HEND).
- Worst-case empty table: 2·NSPR+2 cycles from NEWLINE to HEND.
- Reset asserted mid-scan: immediate return to IDLE with all outputs 0. No HEND after release until the next NEWLINE.

## Test plan
- Empty table (all ACTIVE=0), NEWLINE with LINE=0x40 → no LACH/CARY; HEND exactly 2·128+1 cycles after the NEWLINE cycle; BUSY high in between.
- One entry at index 5: Y=0x3C, X=0x123, COLOR=0xA5, WM1=3, HFLIP=0, CODE=0x155; LINE=0x40 → LACH with HP=0x123, OC=0xA5, OHF=0; 4 CARYs 4 cycles apart with CA = {0x155, 4'h4, 0..3}.
- Same entry with HFLIP=1 → OHF=1; CA chunk sequence 3,2,1,0.
- Y=0xFA, LINE=0x03 → visible, row=9; Y=0x30, LINE=0x40 → d=16, invisible, no LACH.
- 40 visible sprites with MAXSPR=32 → exactly 32 LACH pulses, then HEND right after the 32nd sprite's last slot; remaining entries are not fetched.
- NEWLINE mid-DRAW → CARY sequence stops, no HEND for the old line, ATTR_A=0 on the next cycle; nRES low mid-DRAW → all outputs 0 asynchronously.
